// File: rtl/k12a_spi_master_multi.sv
// k12a_spi_master_multi: multi-channel SPI master with a start/busy/done handshake.
// One transfer runs at a time on the latched channel. The runtime divider sets
// the SCK half-period, and the latched cpol/cpha/lsb_first select the mode and
// bit order.
module k12a_spi_master_multi #(
    parameter int NUM_CHANNELS = 2,
    parameter int DATA_WIDTH   = 8,
    parameter int DIV_WIDTH    = 8,
    localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                    cpu_clock,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [CW-1:0]           chan_sel,
    input  logic [DATA_WIDTH-1:0]   tx_data,
    input  logic                    cpol,
    input  logic                    cpha,
    input  logic                    lsb_first,
    input  logic [DIV_WIDTH-1:0]    clk_div,
    output logic                    busy,
    output logic                    done,
    output logic [DATA_WIDTH-1:0]   rx_data,
    output logic [NUM_CHANNELS-1:0] spi_sck,
    output logic [NUM_CHANNELS-1:0] spi_mosi,
    input  logic [NUM_CHANNELS-1:0] spi_miso
);

    localparam int HW = $clog2(2 * DATA_WIDTH);
    localparam logic [HW-1:0] LAST_HALF = HW'(2 * DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          chan_q, chan_d;
    logic                   cpol_q, cpol_d;
    logic                   cpha_q, cpha_d;
    logic                   lsb_q, lsb_d;
    logic [DIV_WIDTH-1:0]   div_q, div_d;
    logic [DIV_WIDTH-1:0]   div_cnt_q, div_cnt_d;
    logic [HW-1:0]          half_cnt_q, half_cnt_d;
    logic                   sck_q, sck_d;
    logic [DATA_WIDTH-1:0]  tx_q, tx_d;
    logic [DATA_WIDTH-1:0]  rx_sh_q, rx_sh_d;
    logic [DATA_WIDTH-1:0]  rx_data_q, rx_data_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   accept, tick, leading, last_half;
    logic                   sample, shift_tx, miso_act, mosi_bit;
    logic [DATA_WIDTH-1:0]  rx_next;

    // Pick the MISO line of the latched channel.
    always_comb begin
        miso_act = 1'b0;
        for (int i = 0; i < NUM_CHANNELS; i++)
            if (chan_q == CW'(i)) miso_act = spi_miso[i];
    end

    assign mosi_bit = lsb_q ? tx_q[0] : tx_q[DATA_WIDTH-1];

    // Next-state logic: acceptance, divider/half-period counting, TX/RX shifting.
    always_comb begin
        state_d    = state_q;
        chan_d     = chan_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        lsb_d      = lsb_q;
        div_d      = div_q;
        div_cnt_d  = div_cnt_q;
        half_cnt_d = half_cnt_q;
        sck_d      = sck_q;
        tx_d       = tx_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        // A new transfer may start in IDLE or on the DONE cycle's edge (back-to-back).
        accept    = (state_q != SHIFT) && start && (32'(chan_sel) < 32'(NUM_CHANNELS));
        tick      = (div_cnt_q == div_q);
        leading   = ~half_cnt_q[0];
        last_half = (half_cnt_q == LAST_HALF);
        // cpha=0 samples on leading edges, cpha=1 on trailing edges.
        sample    = leading ^ cpha_q;
        // cpha=0: advance on trailing edges except the last one.
        // cpha=1: drive a new bit on every leading edge after the first.
        shift_tx  = cpha_q ? (leading && (half_cnt_q != '0)) : (!leading && !last_half);

        if (sample)
            rx_next = lsb_q ? {miso_act, rx_sh_q[DATA_WIDTH-1:1]}
                            : {rx_sh_q[DATA_WIDTH-2:0], miso_act};
        else
            rx_next = rx_sh_q;

        case (state_q)
            SHIFT: begin
                if (tick) begin
                    div_cnt_d  = '0;
                    sck_d      = ~sck_q;
                    half_cnt_d = half_cnt_q + HW'(1);
                    rx_sh_d    = rx_next;
                    if (shift_tx)
                        tx_d = lsb_q ? (tx_q >> 1) : (tx_q << 1);
                    if (last_half) begin
                        state_d   = DONE;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        rx_data_d = rx_next;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
                sck_d   = cpol_q;
                if (accept) begin
                    state_d    = SHIFT;
                    busy_d     = 1'b1;
                    chan_d     = chan_sel;
                    cpol_d     = cpol;
                    cpha_d     = cpha;
                    lsb_d      = lsb_first;
                    div_d      = clk_div;
                    div_cnt_d  = '0;
                    half_cnt_d = '0;
                    sck_d      = cpol;
                    tx_d       = tx_data;
                    rx_sh_d    = '0;
                end
            end
        endcase
    end

    // State and registered outputs; reset clears everything immediately.
    always_ff @(posedge cpu_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            chan_q     <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            lsb_q      <= 1'b0;
            div_q      <= '0;
            div_cnt_q  <= '0;
            half_cnt_q <= '0;
            sck_q      <= 1'b0;
            tx_q       <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            chan_q     <= chan_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            lsb_q      <= lsb_d;
            div_q      <= div_d;
            div_cnt_q  <= div_cnt_d;
            half_cnt_q <= half_cnt_d;
            sck_q      <= sck_d;
            tx_q       <= tx_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;

    // Only the latched channel sees the shifting clock and data. Idle channels
    // sit at the latched cpol with MOSI low.
    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        assign spi_sck[i]  = (chan_q == CW'(i)) ? sck_q : cpol_q;
        assign spi_mosi[i] = busy_q && (chan_q == CW'(i)) && mosi_bit;
    end

endmodule
